// File: rtl/ets_sweep_controller.sv
// Sweeps the ETS clock phase across a programmed range, taking one offset-sampler
// measurement per point and writing the one-count into the capture buffer.
module ets_sweep_controller #(
   parameter int ADDR_WIDTH    = 8,
   parameter int OFFSET_WIDTH  = 16,
   parameter int SETTLE_CYCLES = 16,
   parameter int ACK_TIMEOUT   = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [OFFSET_WIDTH-1:0] first_offset,
   input  logic [OFFSET_WIDTH-1:0] offset_step,
   input  logic [ADDR_WIDTH:0]     num_points,
   output logic [OFFSET_WIDTH-1:0] phase_offset,
   output logic                    phase_req,
   input  logic                    phase_ack,
   output logic                    sampler_request_run,
   input  logic                    sampler_running,
   input  logic                    sampler_result_ready,
   input  logic [31:0]             sampler_result,
   output logic                    wr_en,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [31:0]             wr_data,
   output logic                    busy,
   output logic                    done,
   output logic                    fault
);

   localparam int CNT_MAX = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SET_PHASE, S_SETTLE, S_RUN, S_WAIT_RESULT, S_STORE, S_DRAIN, S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [OFFSET_WIDTH-1:0] off_q, off_d;
   logic [OFFSET_WIDTH-1:0] step_q, step_d;
   logic [ADDR_WIDTH:0]     np_q, np_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [OFFSET_WIDTH-1:0] phase_offset_q, phase_offset_d;
   logic                    phase_req_q, phase_req_d;
   logic                    sampler_request_run_q, sampler_request_run_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [31:0]             wr_data_q, wr_data_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    fault_q, fault_d;

   always_comb begin
      state_d               = state_q;
      idx_d                 = idx_q;
      off_d                 = off_q;
      step_d                = step_q;
      np_d                  = np_q;
      cnt_d                 = cnt_q;
      phase_offset_d        = phase_offset_q;
      phase_req_d           = 1'b0;
      sampler_request_run_d = 1'b0;
      wr_en_d               = 1'b0;
      wr_addr_d             = wr_addr_q;
      wr_data_d             = wr_data_q;
      done_d                = 1'b0;
      fault_d               = fault_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               off_d   = first_offset;
               step_d  = offset_step;
               np_d    = num_points;
               idx_d   = '0;
               cnt_d   = '0;
               fault_d = 1'b0;
               state_d = (num_points == '0) ? S_DONE : S_SET_PHASE;
            end
         end
         S_SET_PHASE: begin
            phase_offset_d = off_q;
            // Ack only counts once our own request is visible, so a stale ack
            // from the previous point cannot be taken for this one.
            if (abort) begin
               state_d = S_DONE;
            end else if (phase_req_q && phase_ack) begin
               cnt_d   = '0;
               state_d = S_SETTLE;
            end else if (phase_req_q && cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               fault_d = 1'b1;
               state_d = S_DONE;
            end else begin
               phase_req_d = 1'b1;
               if (phase_req_q) cnt_d = cnt_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (abort)                                       state_d = S_DONE;
            else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1))     state_d = S_RUN;
            else                                             cnt_d   = cnt_q + 1'b1;
         end
         S_RUN: begin
            // A sampler left running by a reset must go idle before we request.
            if (abort)                                          state_d = S_DRAIN;
            else if (sampler_request_run_q && sampler_running)  state_d = S_WAIT_RESULT;
            else sampler_request_run_d = sampler_request_run_q | ~sampler_running;
         end
         S_WAIT_RESULT: begin
            if (abort) begin
               state_d = S_DRAIN;
            end else if (sampler_result_ready) begin
               wr_data_d = sampler_result;
               state_d   = S_STORE;
            end
         end
         S_STORE: begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            if (abort || {1'b0, idx_q} == np_q - 1'b1) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               off_d   = off_q + step_q;
               cnt_d   = '0;
               state_d = S_SET_PHASE;
            end
         end
         S_DRAIN: begin
            if (!sampler_running && !sampler_result_ready) state_d = S_DONE;
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // busy stays up through the done pulse so the host never sees idle before done
      busy_d = (state_d != S_IDLE) | done_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q               <= S_IDLE;
         idx_q                 <= '0;
         off_q                 <= '0;
         step_q                <= '0;
         np_q                  <= '0;
         cnt_q                 <= '0;
         phase_offset_q        <= '0;
         phase_req_q           <= 1'b0;
         sampler_request_run_q <= 1'b0;
         wr_en_q               <= 1'b0;
         wr_addr_q             <= '0;
         wr_data_q             <= '0;
         busy_q                <= 1'b0;
         done_q                <= 1'b0;
         fault_q               <= 1'b0;
      end else begin
         state_q               <= state_d;
         idx_q                 <= idx_d;
         off_q                 <= off_d;
         step_q                <= step_d;
         np_q                  <= np_d;
         cnt_q                 <= cnt_d;
         phase_offset_q        <= phase_offset_d;
         phase_req_q           <= phase_req_d;
         sampler_request_run_q <= sampler_request_run_d;
         wr_en_q               <= wr_en_d;
         wr_addr_q             <= wr_addr_d;
         wr_data_q             <= wr_data_d;
         busy_q                <= busy_d;
         done_q                <= done_d;
         fault_q               <= fault_d;
      end
   end

   assign phase_offset        = phase_offset_q;
   assign phase_req           = phase_req_q;
   assign sampler_request_run = sampler_request_run_q;
   assign wr_en               = wr_en_q;
   assign wr_addr             = wr_addr_q;
   assign wr_data             = wr_data_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign fault               = fault_q;

endmodule
